// File: rtl/demux4_rr_sched.sv
// demux4_rr_sched: round-robin burst scheduler feeding a single-entry buffer ahead of a 4-way demux
//   in_data/in_valid/in_ready : input stream (in_ready combinational, 0 during rst)
//   en                        : channel enable mask, bit k = channel k (A..D)
//   out_data/out_valid        : buffered word, one-hot destination channel
//   out_ready                 : per-channel sink ready
//   S1,S0                     : channel assigned to the next accepted input
//   busy                      : buffer occupied
module demux4_rr_sched #(
    parameter int W     = 8,
    parameter int BURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   en,
    output logic [W-1:0] out_data,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready,
    output logic         S0,
    output logic         S1,
    output logic         busy
);
    logic [1:0]   sel, buf_ch, nxt_sel;
    logic [7:0]   beat;
    logic         full, aligned, accept, drain, last;
    logic [W-1:0] buf_data;

    assign aligned   = en[sel];
    assign drain     = full && out_ready[buf_ch];
    assign in_ready  = !rst && aligned && (!full || out_ready[buf_ch]);
    assign accept    = in_valid && in_ready;
    assign last      = beat == 8'(BURST - 1);
    assign out_valid = full ? (4'b0001 << buf_ch) : 4'b0000;
    assign out_data  = buf_data;
    assign busy      = full;
    assign S0        = sel[0];
    assign S1        = sel[1];

    // First enabled channel searching sel+1, sel+2, sel+3, sel; descending
    // loop lets the nearest candidate win. Holds sel when en is all zero.
    always_comb begin
        nxt_sel = sel;
        for (int i = 4; i >= 1; i--)
            if (en[sel + 2'(i)]) nxt_sel = sel + 2'(i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel      <= '0;
            beat     <= '0;
            full     <= 1'b0;
            buf_ch   <= '0;
            buf_data <= '0;
        end else if (accept) begin
            buf_data <= in_data;
            buf_ch   <= sel;
            full     <= 1'b1;
            beat     <= last ? 8'd0 : beat + 8'd1;
            if (last) sel <= nxt_sel;
        end else begin
            if (drain) full <= 1'b0;
            // sel points at a masked channel: abandon the burst and move on
            if (en != 4'b0000 && !aligned) begin
                sel  <= nxt_sel;
                beat <= '0;
            end
        end
    end
endmodule

// File: tb/tb_demux4_rr_sched.sv
// tb_demux4_rr_sched: directed checks of demux4_rr_sched at BURST=1, 2 and 4
module tb_demux4_rr_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic [3:0] en = 4'b1111;
    logic [3:0] out_ready = 4'b1111;
    int         checks = 0;
    int         errors = 0;

    logic [7:0] d1, d2, d4;
    logic [3:0] v1, v2, v4;
    logic       r1, r2, r4, b1, b2, b4;
    logic       s01, s11, s02, s12, s04, s14;

    demux4_rr_sched #(.W(8), .BURST(1)) u1 (.clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(r1), .en(en), .out_data(d1), .out_valid(v1), .out_ready(out_ready), .S0(s01), .S1(s11), .busy(b1));
    demux4_rr_sched #(.W(8), .BURST(2)) u2 (.clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(r2), .en(en), .out_data(d2), .out_valid(v2), .out_ready(out_ready), .S0(s02), .S1(s12), .busy(b2));
    demux4_rr_sched #(.W(8), .BURST(4)) u4 (.clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(r4), .en(en), .out_data(d4), .out_valid(v4), .out_ready(out_ready), .S0(s04), .S1(s14), .busy(b4));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        tick();
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        // reset state
        #3;
        chk("rst_ov", v2, 4'b0000);
        chk("rst_od", d2, 8'h00);
        chk("rst_busy", b2, 1'b0);
        chk("rst_sel", {s12, s02}, 2'b00);
        in_valid = 1'b1;
        #1;
        chk("rst_ir", r2, 1'b0);
        in_valid = 1'b0;
        tick();

        // BURST=2, all enabled, continuous stream 1..8
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            in_data = 8'(k);
            in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("t1_ir%0d", k), r2, 1'b1);
            if (k > 1) begin
                chk($sformatf("t1_ov%0d", k - 1), v2, 4'b0001 << ((k - 2) / 2));
                chk($sformatf("t1_od%0d", k - 1), d2, 8'(k - 1));
            end else
                chk("t1_ov0", v2, 4'b0000);
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1_ov8", v2, 4'b1000);
        chk("t1_od8", d2, 8'd8);
        chk("t1_sel_wrap", {s12, s02}, 2'b00);
        tick();
        @(negedge clk);
        chk("t1_drained", b2, 1'b0);

        // BURST=1, en=1010: bubble, then channels 1,3,1
        reset_all();
        rst = 1'b0;
        en = 4'b1010;
        in_valid = 1'b1;
        in_data = 8'h11;
        @(negedge clk);
        chk("t2_bubble_ir", r1, 1'b0);
        chk("t2_bubble_sel", {s11, s01}, 2'b00);
        tick();
        @(negedge clk);
        chk("t2_ir", r1, 1'b1);
        chk("t2_sel1", {s11, s01}, 2'b01);
        tick();
        in_data = 8'h22;
        @(negedge clk);
        chk("t2_ov11", v1, 4'b0010);
        chk("t2_od11", d1, 8'h11);
        chk("t2_sel3", {s11, s01}, 2'b11);
        tick();
        in_data = 8'h33;
        @(negedge clk);
        chk("t2_ov22", v1, 4'b1000);
        chk("t2_od22", d1, 8'h22);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t2_ov33", v1, 4'b0010);
        chk("t2_od33", d1, 8'h33);

        // backpressure on channel 0 (BURST=2)
        reset_all();
        rst = 1'b0;
        en = 4'b1111;
        out_ready = 4'b1110;
        in_valid = 1'b1;
        in_data = 8'hA1;
        @(negedge clk);
        chk("t3_ir_empty", r2, 1'b1);
        tick();
        in_data = 8'hA2;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("t3_ir_bp%0d", k), r2, 1'b0);
            chk($sformatf("t3_ov_bp%0d", k), v2, 4'b0001);
            chk($sformatf("t3_od_bp%0d", k), d2, 8'hA1);
            tick();
        end
        out_ready = 4'b1111;
        @(negedge clk);
        chk("t3_ir_refill", r2, 1'b1);
        chk("t3_od_refill", d2, 8'hA1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_ov_a2", v2, 4'b0001);
        chk("t3_od_a2", d2, 8'hA2);

        // mid-burst mask change (BURST=4)
        reset_all();
        rst = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hB1;
        tick();
        in_data = 8'hB2;
        tick();
        en = 4'b0100;
        in_data = 8'hC1;
        @(negedge clk);
        chk("t4_ir_masked", r4, 1'b0);
        chk("t4_ov_b2", v4, 4'b0001);
        chk("t4_od_b2", d4, 8'hB2);
        tick();
        @(negedge clk);
        chk("t4_ir_realign", r4, 1'b1);
        chk("t4_sel2", {s14, s04}, 2'b10);
        chk("t4_busy_bubble", b4, 1'b0);
        for (int j = 1; j <= 4; j++) begin
            tick();
            if (j < 4) in_data = 8'hC1 + 8'(j);
            else in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("t4_ov_c%0d", j), v4, 4'b0100);
            chk($sformatf("t4_od_c%0d", j), d4, 8'hC0 + 8'(j));
        end
        chk("t4_beat_wrap", u4.beat, 8'd0);
        chk("t4_sel_stay", {s14, s04}, 2'b10);

        // en=0 while 0x5A waits for channel 3 (BURST=1)
        reset_all();
        rst = 1'b0;
        en = 4'b1000;
        out_ready = 4'b0000;
        in_valid = 1'b1;
        in_data = 8'h5A;
        tick();
        @(negedge clk);
        chk("t5_ir_ch3", r1, 1'b1);
        tick();
        en = 4'b0000;
        in_data = 8'h66;
        @(negedge clk);
        chk("t5_ir_en0", r1, 1'b0);
        chk("t5_ov_held", v1, 4'b1000);
        chk("t5_od_held", d1, 8'h5A);
        chk("t5_busy_held", b1, 1'b1);
        tick();
        out_ready = 4'b1000;
        @(negedge clk);
        chk("t5_ir_drain", r1, 1'b0);
        chk("t5_ov_drain", v1, 4'b1000);
        tick();
        @(negedge clk);
        chk("t5_busy_after", b1, 1'b0);
        chk("t5_ov_after", v1, 4'b0000);
        chk("t5_sel_hold", {s11, s01}, 2'b11);

        // asynchronous reset mid-burst (BURST=4)
        reset_all();
        rst = 1'b0;
        en = 4'b1111;
        out_ready = 4'b1111;
        in_valid = 1'b1;
        in_data = 8'hD1;
        tick();
        in_data = 8'hD2;
        @(negedge clk);
        chk("t6_busy_pre", b4, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_ov_async", v4, 4'b0000);
        chk("t6_od_async", d4, 8'h00);
        chk("t6_busy_async", b4, 1'b0);
        chk("t6_ir_async", r4, 1'b0);
        tick();
        rst = 1'b0;
        in_data = 8'hE1;
        @(negedge clk);
        chk("t6_ir_after", r4, 1'b1);
        chk("t6_sel_after", {s14, s04}, 2'b00);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t6_ov_e1", v4, 4'b0001);
        chk("t6_od_e1", d4, 8'hE1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
